// File: rtl/sha_256_pad.sv
// SHA-224/256 padder: packs message words into 512-bit blocks, appends 0x80 and the bit length; SHA_PAD_ERR_EN adds a sticky Error output.
// Enable pulses the cycle after the 16th/last word is taken; WordReady drops from SEND until the core's Ready frees the block.
module sha_256_pad (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [1:0]   OpIn,
    input  logic [31:0]  Word,
    input  logic         WordValid,
    input  logic         WordLast,
    input  logic [2:0]   WordBytes,
    output logic         WordReady,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic [1:0]   Operation,
    output logic         Enable,
    input  logic         Ready,
    output logic         Done,
    output logic         Busy
`ifdef SHA_PAD_ERR_EN
    ,
    output logic         Error
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;

    logic [2:0]   r_state;
    logic [511:0] r_data;
    logic [63:0]  r_index;
    logic [1:0]   r_op;
    logic [63:0]  r_count;
    logic [3:0]   r_ptr;
    logic         r_final;
    logic         r_pad_pend;
    logic         r_pad_spill;
    logic         r_done;

    logic [2:0]   w_bytes;
    logic [6:0]   w_off;
    logic         w_spill;
    logic         w_fits;
    logic [3:0]   w_ptr_inc;
    logic [63:0]  w_count_nxt;
    logic [63:0]  w_len;
    logic [63:0]  w_len_cur;
    logic [31:0]  w_masked;
    logic [511:0] w_blk;
    logic [511:0] w_pad_blk;
    logic         w_accept;

    assign w_bytes     = (WordBytes > 3'd4) ? 3'd4 : WordBytes;
    assign w_ptr_inc   = r_ptr + 4'd1;
    assign w_count_nxt = r_count + {61'd0, w_bytes};
    assign w_len       = w_count_nxt << 3;
    assign w_len_cur   = r_count << 3;
    // Byte offset of the 0x80 marker; 64 means it spilled out of this block.
    assign w_off       = {1'b0, r_ptr, 2'b00} + {4'd0, w_bytes};
    assign w_spill     = w_off[6];
    assign w_fits      = (w_off <= 7'd55);

`ifdef SHA_PAD_ERR_EN
    logic w_bad;
    logic r_error;
    assign w_bad    = WordValid && ((r_state != S_FILL) || (WordBytes > 3'd4) ||
                      ((WordBytes != 3'd4) && !WordLast));
    assign w_accept = (r_state == S_FILL) && WordValid && !w_bad;
    assign Error    = r_error;

    always_ff @(posedge clk) begin
        if (rst)
            r_error <= 1'b0;
        else if (w_bad)
            r_error <= 1'b1;
        else if ((r_state == S_IDLE) && Start)
            r_error <= 1'b0;
    end
`else
    assign w_accept = (r_state == S_FILL) && WordValid;
`endif

    always_comb begin
        w_masked = '0;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < w_bytes)
                w_masked[31-8*j -: 8] = Word[31-8*j -: 8];
            else if ((3'(j) == w_bytes) && WordLast)
                w_masked[31-8*j -: 8] = 8'h80;
        end
    end

    always_comb begin
        w_blk = r_data;
        w_blk[{r_ptr, 5'd0} +: 32] = w_masked;
        if (WordLast && (w_bytes == 3'd4) && !w_spill)
            w_blk[{w_ptr_inc, 5'd0} +: 32] = 32'h8000_0000;
        if (WordLast && w_fits) begin
            w_blk[14*32 +: 32] = w_len[63:32];
            w_blk[15*32 +: 32] = w_len[31:0];
        end
    end

    always_comb begin
        w_pad_blk          = '0;
        w_pad_blk[31:0]    = r_pad_spill ? 32'h8000_0000 : 32'h0;
        w_pad_blk[14*32 +: 32] = w_len_cur[63:32];
        w_pad_blk[15*32 +: 32] = w_len_cur[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_index     <= '0;
            r_op        <= '0;
            r_count     <= '0;
            r_ptr       <= '0;
            r_final     <= 1'b0;
            r_pad_pend  <= 1'b0;
            r_pad_spill <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op        <= OpIn;
                        r_count     <= '0;
                        r_ptr       <= '0;
                        r_data      <= '0;
                        r_index     <= 64'd1;
                        r_final     <= 1'b0;
                        r_pad_pend  <= 1'b0;
                        r_pad_spill <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_data  <= w_blk;
                        r_count <= w_count_nxt;
                        r_ptr   <= w_ptr_inc;
                        if (WordLast) begin
                            r_final     <= w_fits;
                            r_pad_pend  <= !w_fits;
                            r_pad_spill <= w_spill;
                            r_state     <= S_SEND;
                        end else if (r_ptr == 4'd15) begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_SEND: r_state <= S_WAIT;
                S_WAIT: begin
                    if (Ready) begin
                        if (r_final) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_index <= r_index + 64'd1;
                            r_data  <= '0;
                            r_ptr   <= '0;
                            r_state <= r_pad_pend ? S_PAD : S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    r_data     <= w_pad_blk;
                    r_final    <= 1'b1;
                    r_pad_pend <= 1'b0;
                    r_state    <= S_SEND;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign WordReady = (r_state == S_FILL);
    assign Enable    = (r_state == S_SEND);
    assign Busy      = (r_state != S_IDLE);
    assign Data      = r_data;
    assign Index     = r_index;
    assign Operation = r_op;
    assign Done      = r_done;

endmodule

// File: tb/tb_sha_256_pad.sv
// Bench for sha_256_pad: a byte-level padding model predicts every block, checked whenever Enable is high.
module tb_sha_256_pad;

    logic         clk = 1'b0;
    logic         rst, Start, WordValid, WordLast, WordReady, Enable, Ready, Done, Busy;
    logic [1:0]   OpIn, Operation;
    logic [31:0]  Word;
    logic [2:0]   WordBytes;
    logic [511:0] Data;
    logic [63:0]  Index;

    sha_256_pad dut (
        .clk(clk), .rst(rst), .Start(Start), .OpIn(OpIn), .Word(Word),
        .WordValid(WordValid), .WordLast(WordLast), .WordBytes(WordBytes),
        .WordReady(WordReady), .Data(Data), .Index(Index), .Operation(Operation),
        .Enable(Enable), .Ready(Ready), .Done(Done), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  idx;
        logic [1:0]   op;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] blk_log[$];
    logic [7:0]   msg_b[0:255];
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_cnt = 0;
    bit           auto_ready = 1'b1;
    int           ready_delay = 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
        return b[i*32 +: 32];
    endfunction

    task automatic fill_pattern(input int len, input int seed);
        for (int i = 0; i < len; i++) msg_b[i] = 8'(i * 13 + seed);
    endtask

    // Standard SHA-2 padding on a byte stream, then cut into 64-byte blocks.
    task automatic model_push(input int len, input logic [1:0] op);
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        exp_t         e;
        for (int i = 0; i < len; i++) p.push_back(msg_b[i]);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[k*8 +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int w = 0; w < 16; w++)
                blk[w*32 +: 32] = {p[b*64+w*4], p[b*64+w*4+1], p[b*64+w*4+2], p[b*64+w*4+3]};
            e.d = blk;
            e.idx = 64'(b + 1);
            e.op = op;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_msg(input int len, input logic [1:0] op);
        int nwords, nb, t;
        logic [31:0] w;
        nwords = (len == 0) ? 1 : (len + 3) / 4;
        @(negedge clk); Start = 1'b1; OpIn = op;
        @(negedge clk); Start = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            nb = len - 4 * k;
            if (nb > 4) nb = 4;
            w = 32'hAAAA_AAAA;
            for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg_b[4*k+j];
            Word = w; WordBytes = 3'(nb); WordLast = (k == nwords - 1); WordValid = 1'b1;
            t = 0;
            while (!WordReady && t < 400) begin @(negedge clk); t++; end
            if (t >= 400) begin
                n_checks++; n_fail++;
                $display("FAIL word_ready_timeout: got WordReady=0 for %0d cycles expected 1", t);
            end
            @(negedge clk);
        end
        WordValid = 1'b0; WordLast = 1'b0;
        check("enable_latency", Enable, 1);
    endtask

    task automatic run_msg(input int len, input logic [1:0] op, input int delay, input bit poke);
        int base, t;
        ready_delay = delay;
        blk_log.delete();
        base = done_cnt;
        model_push(len, op);
        drive_msg(len, op);
        if (poke) begin
            @(negedge clk); Start = 1'b1; OpIn = ~op;
            @(negedge clk); Start = 1'b0; OpIn = op;
        end
        t = 0;
        while (done_cnt == base && t < 3000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt - base, 1);
        check("blocks_left", exp_q.size(), 0);
    endtask

    // Compare every presented block against the model.
    initial begin
        logic prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (Done) done_cnt++;
            if (Enable) begin
                check("enable_one_cycle", prev_en, 0);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_block: got Enable with Index %0d expected none", Index);
                end else begin
                    e = exp_q.pop_front();
                    check("data", Data, e.d);
                    check("index", Index, e.idx);
                    check("operation", Operation, e.op);
                end
                blk_log.push_back(Data);
            end
            prev_en = Enable;
        end
    end

    // Core stand-in: holds Ready off while checking the block stays frozen.
    initial begin
        logic [511:0] cap;
        forever begin
            @(negedge clk);
            if (Enable && auto_ready) begin
                cap = Data;
                repeat (ready_delay + 1) begin
                    @(negedge clk);
                    check("stall_data", Data, cap);
                    check("stall_wordready", WordReady, 0);
                end
                Ready = 1'b1;
                @(negedge clk);
                Ready = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; Start = 1'b0; OpIn = 2'd0; Word = '0; WordValid = 1'b0;
        WordLast = 1'b0; WordBytes = 3'd0; Ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", Busy, 0);
        check("rst_wordready", WordReady, 0);
        check("rst_enable", Enable, 0);
        check("rst_done", Done, 0);
        check("rst_index", Index, 0);
        check("rst_operation", Operation, 0);
        check("rst_data", Data, 0);

        // Word offered while idle must be ignored.
        Word = 32'h1234_5678; WordBytes = 3'd4; WordValid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_word_busy", Busy, 0);
        check("idle_word_index", Index, 0);
        WordValid = 1'b0;

        msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
        run_msg(3, 2'd1, 1, 1'b0);
        check("abc_blocks", blk_log.size(), 1);
        if (blk_log.size() >= 1) begin
            check("abc_w0", word_of(blk_log[0], 0), 32'h6162_6380);
            check("abc_w1", word_of(blk_log[0], 1), 32'h0);
            check("abc_w15", word_of(blk_log[0], 15), 32'h0000_0018);
        end

        run_msg(0, 2'd1, 0, 1'b0);
        check("empty_blocks", blk_log.size(), 1);
        if (blk_log.size() >= 1) begin
            check("empty_w0", word_of(blk_log[0], 0), 32'h8000_0000);
            check("empty_w15", word_of(blk_log[0], 15), 32'h0);
        end

        fill_pattern(56, 3);
        run_msg(56, 2'd0, 2, 1'b0);
        check("b56_blocks", blk_log.size(), 2);
        if (blk_log.size() >= 2) begin
            check("b56_1_w14", word_of(blk_log[0], 14), 32'h8000_0000);
            check("b56_1_w15", word_of(blk_log[0], 15), 32'h0);
            check("b56_2_w0", word_of(blk_log[1], 0), 32'h0);
            check("b56_2_w15", word_of(blk_log[1], 15), 32'h0000_01C0);
        end

        fill_pattern(64, 7);
        run_msg(64, 2'd1, 70, 1'b1);
        check("b64_blocks", blk_log.size(), 2);
        if (blk_log.size() >= 2) begin
            check("b64_2_w0", word_of(blk_log[1], 0), 32'h8000_0000);
            check("b64_2_w15", word_of(blk_log[1], 15), 32'h0000_0200);
        end

        fill_pattern(55, 11); run_msg(55, 2'd1, 1, 1'b0);
        check("b55_blocks", blk_log.size(), 1);
        fill_pattern(59, 5);  run_msg(59, 2'd0, 3, 1'b0);
        check("b59_blocks", blk_log.size(), 2);
        fill_pattern(70, 9);  run_msg(70, 2'd1, 1, 1'b0);
        if (blk_log.size() >= 2)
            check("b70_2_w15", word_of(blk_log[1], 15), 32'h0000_0230);

        // Reset while waiting on the core: message abandoned, no Done.
        auto_ready = 1'b0;
        fill_pattern(5, 1);
        model_push(5, 2'd1);
        base = done_cnt;
        drive_msg(5, 2'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wait_rst_busy", Busy, 0);
        check("wait_rst_enable", Enable, 0);
        check("wait_rst_wordready", WordReady, 0);
        check("wait_rst_index", Index, 0);
        check("wait_rst_data", Data, 0);
        check("wait_rst_operation", Operation, 0);
        repeat (5) @(negedge clk);
        check("wait_rst_no_done", done_cnt - base, 0);
        check("wait_rst_blocks", exp_q.size(), 0);
        auto_ready = 1'b1;

        fill_pattern(130, 17);
        run_msg(130, 2'd0, 1, 1'b0);
        check("b130_blocks", blk_log.size(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
